alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Alarm stage directly downstream of the calendar clock counter. Consumes the live hrs/min/sec
//  outputs (clock advances one second per clk), holds a programmable HH:MM alarm time and
//  drives a ring request through an IDLE/ARMED/RINGING/SNOOZE state machine with timeout.
// PARAMETERS
//  RING_SEC    60  cycles (seconds) RINGING lasts before auto-stop; legal 1..255
//  SNOOZE_MIN  9   minutes added to current time on snooze; legal 1..59
//  MAX_SNOOZE  3   snoozes allowed per alarm event; legal 1..7
// PORTS
//  clk         in   1   clock, one tick = one clock second
//  rst_n       in   1   asynchronous active-low reset
//  hrs         in   5   current hour 0..23, from clock stage
//  min         in   6   current minute 0..59
//  sec         in   6   current second 0..59
//  set_valid   in   1   load set_hrs/set_min as alarm time this cycle
//  set_hrs     in   5   alarm hour
//  set_min     in   6   alarm minute
//  arm         in   1   IDLE->ARMED request
//  disarm      in   1   any state -> IDLE
//  stop        in   1   end current ring/snooze, stay armed
//  snooze      in   1   defer current ring by SNOOZE_MIN
//  ring        out  1   registered ring request
//  alarm_state out  2   IDLE=0 ARMED=1 RINGING=2 SNOOZE=3
//  snooze_cnt  out  3   snoozes used in current alarm event
//  set_err     out  1   one-cycle pulse: set rejected (hrs>23 or min>59)
// BEHAVIOUR
//  - Reset: state IDLE, ring 0, snooze_cnt 0, set_err 0, alarm time 00:00, snooze target 00:00, ring_cnt 0.
//  - All outputs registered; state/ring change the cycle after the causing input or match.
//  - set_valid legal in any state: updates alarm time, never the snooze target; out-of-range ->
//    time unchanged, set_err=1 next cycle. Match in the same cycle uses the old alarm time.
//  - match_a = (hrs==alm_h && min==alm_m && sec==0); match_s same against snooze target.
//  - Priority per cycle: disarm > stop > snooze > ring timeout > match. arm only acts in IDLE.
//  - IDLE: arm -> ARMED.
//  - ARMED: match_a -> RINGING (ring=1, ring_cnt=0).
//  - RINGING: ring_cnt++ each cycle; stop, or ring_cnt==RING_SEC-1 -> ARMED (ring=0);
//    snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, target=(hrs:min + SNOOZE_MIN) mod 24h,
//    snooze_cnt++; snooze at MAX_SNOOZE ignored (keeps ringing to timeout).
//  - SNOOZE: match_s -> RINGING (ring_cnt=0); stop -> ARMED; match_a ignored.
//  - disarm from any state -> IDLE, ring=0. snooze_cnt cleared on every entry to ARMED or IDLE.
//  - Wrap: 23:55+9 -> 00:04; minute carry into hour, hour 23->0; no day/month involvement.
//  - rst_n low mid-ring: ring drops asynchronously, alarm time lost (back to 00:00).
// CONFIGURATION
//  ALARM_SNOOZE_EN defined: snooze path as above.
//  Not defined: snooze input ignored, SNOOZE state unreachable, snooze target/adder absent,
//  snooze_cnt tied 0; RINGING exits only by stop, disarm or timeout.
// STRUCTURE
//  alarm_pkg: state enum (IDLE/ARMED/RINGING/SNOOZE), hour/minute/second widths, limits
//  HRS_MAX=23, MIN_MAX=59, SEC_MAX=59.
//  Sub-module alarm_time_add: combinational HH:MM + minutes with mod-24h wrap; instantiated
//  only under ALARM_SNOOZE_EN.
// TESTING
//  1 set 07:30, arm; drive 07:29:59 -> 07:30:00 -> ring=1, state=RINGING next cycle.
//  2 ringing, hold no input -> ring=0, state=ARMED exactly RING_SEC=60 cycles after ring rose.
//  3 alarm 23:55 ringing at 23:55:03, snooze -> SNOOZE, snooze_cnt=1; at 00:04:00 ring=1.
//  4 three snoozes used, 4th snooze -> stays RINGING, snooze_cnt=3; stop -> ARMED, cnt=0.
//  5 set_hrs=24 -> set_err pulse, alarm unchanged; disarm+stop same cycle in RINGING -> IDLE.
//  6 rst_n low while ringing -> ring=0 immediately; after release IDLE, alarm 00:00.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm stage: field widths, time limits and the
// alarm state encoding (IDLE=0 ARMED=1 RINGING=2 SNOOZE=3).
package alarm_pkg;

  localparam int HRS_W      = 5;
  localparam int MIN_W      = 6;
  localparam int SEC_W      = 6;
  localparam int RING_CNT_W = 8;
  localparam int SNZ_CNT_W  = 3;

  localparam logic [HRS_W-1:0] HRS_MAX = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_t;

  // True when an HH:MM pair is a legal time of day.
  function automatic logic time_ok(input logic [HRS_W-1:0] h, input logic [MIN_W-1:0] m);
    return (h <= HRS_MAX) && (m <= MIN_MAX);
  endfunction

endpackage

// File: rtl/alarm_time_add.sv
// Combinational HH:MM + minutes with a single minute->hour carry and
// 23->0 hour wrap. Inputs are assumed legal (hours 0..23, minutes 0..59,
// addend 1..59), so at most one carry can occur.
module alarm_time_add
  import alarm_pkg::*;
(
  input  logic [HRS_W-1:0] hrs_in,
  input  logic [MIN_W-1:0] min_in,
  input  logic [MIN_W-1:0] add_min,
  output logic [HRS_W-1:0] hrs_out,
  output logic [MIN_W-1:0] min_out
);

  logic [MIN_W:0] min_sum;
  logic           carry;

  // Minute add with carry into the hour, hour wraps at midnight.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    min_sum = {1'b0, min_in} + {1'b0, add_min};
    carry   = (min_sum > {1'b0, MIN_MAX});
    min_out = min_sum[MIN_W-1:0];
    hrs_out = hrs_in;
    if (carry) begin
      min_out = MIN_W'(min_sum - ({1'b0, MIN_MAX} + 7'd1));
      hrs_out = (hrs_in == HRS_MAX) ? '0 : HRS_W'(hrs_in + 1'b1);
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm stage downstream of the calendar clock. Holds an HH:MM alarm time,
// compares it against the live time and drives a registered ring request
// through IDLE/ARMED/RINGING/SNOOZE with a ring timeout.
// Build option: define ALARM_SNOOZE_EN to include the snooze path (target
// register, time adder, snooze counter). Without it the snooze input is
// ignored and snooze_cnt is tied to 0.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 9,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [HRS_W-1:0]     hrs,
  input  logic [MIN_W-1:0]     min,
  input  logic [SEC_W-1:0]     sec,
  input  logic                 set_valid,
  input  logic [HRS_W-1:0]     set_hrs,
  input  logic [MIN_W-1:0]     set_min,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic                 stop,
  input  logic                 snooze,
  output logic                 ring,
  output logic [1:0]           alarm_state,
  output logic [SNZ_CNT_W-1:0] snooze_cnt,
  output logic                 set_err
);

  localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_SEC - 1);

  alarm_state_t          state_q, state_d;
  logic [RING_CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic                  ring_q;
  logic                  set_err_q;
  logic [HRS_W-1:0]      alm_h_q;
  logic [MIN_W-1:0]      alm_m_q;
  logic                  match_a;
  logic                  match_s;
  logic                  snooze_ok;

  assign match_a = (hrs == alm_h_q) && (min == alm_m_q) && (sec == '0);

`ifdef ALARM_SNOOZE_EN
  logic [SNZ_CNT_W-1:0] snz_cnt_q, snz_cnt_d;
  logic [HRS_W-1:0]     snz_h_q, snz_h_d;
  logic [MIN_W-1:0]     snz_m_q, snz_m_d;
  logic                 snz_load;

  alarm_time_add u_time_add (
    .hrs_in  (hrs),
    .min_in  (min),
    .add_min (MIN_W'(SNOOZE_MIN)),
    .hrs_out (snz_h_d),
    .min_out (snz_m_d)
  );

  assign match_s    = (hrs == snz_h_q) && (min == snz_m_q) && (sec == '0);
  assign snooze_ok  = snooze && (snz_cnt_q < SNZ_CNT_W'(MAX_SNOOZE));
  assign snooze_cnt = snz_cnt_q;

  // Snooze target and per-event snooze count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snz_cnt_q <= '0;
      snz_h_q   <= '0;
      snz_m_q   <= '0;
    end else begin
      snz_cnt_q <= snz_cnt_d;
      if (snz_load) begin
        snz_h_q <= snz_h_d;
        snz_m_q <= snz_m_d;
      end
    end
  end
`else
  logic [2:0] unused_snooze;

  assign unused_snooze = {snooze, ^MIN_W'(SNOOZE_MIN), ^SNZ_CNT_W'(MAX_SNOOZE)};
  assign match_s       = 1'b0;
  assign snooze_ok     = 1'b0;
  assign snooze_cnt    = '0;
`endif

  // Next-state logic; priority disarm > stop > snooze > timeout > match.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
    snz_load   = 1'b0;
`endif
    if (disarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (!stop && match_a) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          ring_cnt_d = ring_cnt_q + 1'b1;
          if (stop) begin
            state_d = ST_ARMED;
          end else if (snooze_ok) begin
            state_d = ST_SNOOZE;
`ifdef ALARM_SNOOZE_EN
            snz_load  = 1'b1;
            snz_cnt_d = snz_cnt_q + 1'b1;
`endif
          end else if (ring_cnt_q == RING_LAST) begin
            state_d = ST_ARMED;
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            state_d = ST_ARMED;
          end else if (match_s) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef ALARM_SNOOZE_EN
    // A fresh alarm event starts whenever the machine settles back to ARMED or IDLE.
    if (state_d == ST_IDLE || state_d == ST_ARMED) snz_cnt_d = '0;
`endif
  end

  // State, ring counter and registered ring request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      ring_q     <= 1'b0;
    end else begin
      // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      ring_q     <= (state_d == ST_RINGING);
    end
  end

  // Alarm time register and set-error pulse; a rejected set leaves the time alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the alarm time lives in flops, so reset deliberately wipes it back to 00:00.
      alm_h_q   <= '0;
      alm_m_q   <= '0;
      set_err_q <= 1'b0;
    end else begin
      set_err_q <= set_valid && !time_ok(set_hrs, set_min);
      if (set_valid && time_ok(set_hrs, set_min)) begin
        alm_h_q <= set_hrs;
        alm_m_q <= set_min;
      end
    end
  end

  assign ring        = ring_q;
  assign alarm_state = state_q;
  assign set_err     = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl. Each cycle's expected outputs are
// pushed to a scoreboard when inputs are driven and popped/compared 1ns
// after the following rising edge. Snooze scenarios follow ALARM_SNOOZE_EN.
module tb_alarm_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RING = 2'd2;
  localparam logic [1:0] S_SNZ  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] hrs = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hrs = '0;
  logic [5:0] set_min = '0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       ring;
  logic [1:0] alarm_state;
  logic [2:0] snooze_cnt;
  logic       set_err;

  typedef struct {
    string      tag;
    logic       ring;
    logic [1:0] st;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alarm_ctrl #(.RING_SEC(60), .SNOOZE_MIN(9), .MAX_SNOOZE(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hrs         (hrs),
    .min         (min),
    .sec         (sec),
    .set_valid   (set_valid),
    .set_hrs     (set_hrs),
    .set_min     (set_min),
    .arm         (arm),
    .disarm      (disarm),
    .stop        (stop),
    .snooze      (snooze),
    .ring        (ring),
    .alarm_state (alarm_state),
    .snooze_cnt  (snooze_cnt),
    .set_err     (set_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hrs = 5'(h);
    min = 6'(m);
    sec = 6'(s);
  endtask

  // Push expectation for the coming edge, clock once, then pop and compare.
  task automatic step(input string tag, input logic r, input logic [1:0] s,
                      input logic [2:0] c, input logic e);
    exp_t x;
    sb.push_back('{tag: tag, ring: r, st: s, cnt: c, err: e});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, ".ring"},  32'(ring),        32'(x.ring));
    check({x.tag, ".state"}, 32'(alarm_state), 32'(x.st));
    check({x.tag, ".cnt"},   32'(snooze_cnt),  32'(x.cnt));
    check({x.tag, ".err"},   32'(set_err),     32'(x.err));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.ring",  32'(ring),        32'(0));
    check("rst.state", 32'(alarm_state), 32'(S_IDLE));
    check("rst.cnt",   32'(snooze_cnt),  32'(0));
    check("rst.err",   32'(set_err),     32'(0));
    #10 rst_n = 1'b1;

    // 1: set 07:30, arm, match at 07:30:00
    set_time(7, 29, 0);
    set_valid = 1'b1; set_hrs = 5'd7; set_min = 6'd30;
    step("t1.set", 0, S_IDLE, 0, 0);
    set_valid = 1'b0; arm = 1'b1;
    step("t1.arm", 0, S_ARM, 0, 0);
    arm = 1'b0; set_time(7, 29, 59);
    step("t1.pre", 0, S_ARM, 0, 0);
    set_time(7, 30, 0);
    step("t1.match", 1, S_RING, 0, 0);

    // 2: timeout exactly 60 cycles after ring rose
    for (int i = 1; i < 60; i++) begin
      set_time(7, 30, i);
      step($sformatf("t2.hold%0d", i), 1, S_RING, 0, 0);
    end
    set_time(7, 31, 0);
    step("t2.timeout", 0, S_ARM, 0, 0);

    // 5a: out-of-range sets pulse set_err and leave alarm at 07:30
    set_valid = 1'b1; set_hrs = 5'd24; set_min = 6'd0;
    step("t5.badh", 0, S_ARM, 0, 1);
    set_hrs = 5'd7; set_min = 6'd60;
    step("t5.badm", 0, S_ARM, 0, 1);
    set_valid = 1'b0;
    step("t5.errclr", 0, S_ARM, 0, 0);
    set_time(7, 30, 0);
    step("t5.keep", 1, S_RING, 0, 0);
    set_time(7, 30, 1); stop = 1'b1;
    step("t5.stop", 0, S_ARM, 0, 0);
    stop = 1'b0;

    // Same-cycle set uses the old alarm time for the match
    set_time(7, 30, 0);
    set_valid = 1'b1; set_hrs = 5'd8; set_min = 6'd0;
    step("old.match", 1, S_RING, 0, 0);
    set_valid = 1'b0; set_time(7, 30, 1); stop = 1'b1;
    step("old.stop", 0, S_ARM, 0, 0);
    stop = 1'b0; set_time(7, 30, 0);
    step("old.nomatch", 0, S_ARM, 0, 0);
    set_time(8, 0, 0);
    step("new.match", 1, S_RING, 0, 0);

`ifdef ALARM_SNOOZE_EN
    set_time(8, 0, 1); snooze = 1'b1;
    step("snz.once", 0, S_SNZ, 1, 0);
    snooze = 1'b0; set_time(8, 0, 2); stop = 1'b1;
    step("snz.stop", 0, S_ARM, 0, 0);
`else
    set_time(8, 0, 1); snooze = 1'b1;
    step("snz.ign", 1, S_RING, 0, 0);
    snooze = 1'b0; set_time(8, 0, 2); stop = 1'b1;
    step("snz.stop", 0, S_ARM, 0, 0);
`endif
    stop = 1'b0;

    // Move alarm to 23:55
    set_time(8, 0, 3);
    set_valid = 1'b1; set_hrs = 5'd23; set_min = 6'd55;
    step("t3.set", 0, S_ARM, 0, 0);
    set_valid = 1'b0;
    set_time(23, 55, 0);
    step("t3.ring", 1, S_RING, 0, 0);

`ifdef ALARM_SNOOZE_EN
    // 3: snooze at 23:55:03 -> target 00:04 across midnight
    set_time(23, 55, 3); snooze = 1'b1;
    step("t3.snz", 0, S_SNZ, 1, 0);
    snooze = 1'b0; set_time(23, 55, 0);
    step("t3.ignA", 0, S_SNZ, 1, 0);
    set_time(0, 3, 59);
    step("t3.pre", 0, S_SNZ, 1, 0);
    set_time(0, 4, 0);
    step("t3.wrap", 1, S_RING, 1, 0);

    // 4: use all three snoozes, fourth is ignored, stop clears count
    set_time(0, 4, 5); snooze = 1'b1;
    step("t4.snz2", 0, S_SNZ, 2, 0);
    snooze = 1'b0; set_time(0, 13, 0);
    step("t4.ring2", 1, S_RING, 2, 0);
    set_time(0, 13, 10); snooze = 1'b1;
    step("t4.snz3", 0, S_SNZ, 3, 0);
    snooze = 1'b0; set_time(0, 22, 0);
    step("t4.ring3", 1, S_RING, 3, 0);
    set_time(0, 22, 1); snooze = 1'b1;
    step("t4.snz4", 1, S_RING, 3, 0);
    snooze = 1'b0; set_time(0, 22, 2); stop = 1'b1;
    step("t4.stop", 0, S_ARM, 0, 0);
`else
    set_time(23, 55, 3); snooze = 1'b1;
    step("t3.ign", 1, S_RING, 0, 0);
    snooze = 1'b0; set_time(23, 55, 4); stop = 1'b1;
    step("t3.stop", 0, S_ARM, 0, 0);
`endif
    stop = 1'b0;

    // 5b: disarm beats stop while ringing
    set_time(23, 55, 0);
    step("t5.ring", 1, S_RING, 0, 0);
    set_time(23, 55, 1); disarm = 1'b1; stop = 1'b1;
    step("t5.disarm", 0, S_IDLE, 0, 0);
    disarm = 1'b0; stop = 1'b0;

    // 6: reset while ringing drops ring at once and loses the alarm time
    arm = 1'b1;
    step("t6.arm", 0, S_ARM, 0, 0);
    arm = 1'b0; set_time(23, 55, 0);
    step("t6.ring", 1, S_RING, 0, 0);
    rst_n = 1'b0;
    #1;
    check("t6.async.ring",  32'(ring),        32'(0));
    check("t6.async.state", 32'(alarm_state), 32'(S_IDLE));
    #1 rst_n = 1'b1;
    step("t6.idle", 0, S_IDLE, 0, 0);
    arm = 1'b1;
    step("t6.rearm", 0, S_ARM, 0, 0);
    arm = 1'b0;
    step("t6.lost", 0, S_ARM, 0, 0);
    set_time(0, 0, 0);
    step("t6.zero", 1, S_RING, 0, 0);
    disarm = 1'b1;
    step("t6.end", 0, S_IDLE, 0, 0);
    disarm = 1'b0;

    check("sb.empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
